// File: rtl/apb_master_bridge_if.sv
// Local request bus plus the four-slot APB bus driven by apb_master_bridge.
// master: bridge view; slave: the requester/peripheral side that drives requests and slave responses.
interface apb_master_bridge_if;
  logic        transfer;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic        PENABLE;
  logic        PSEL0, PSEL1, PSEL2, PSEL3;
  logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
  logic        PREADY0, PREADY1, PREADY2, PREADY3;

  modport master (
    input  transfer, write, addr, wdata,
    input  PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    input  PREADY0, PREADY1, PREADY2, PREADY3,
    output ready, rdata, PADDR, PWRITE, PWDATA, PENABLE,
    output PSEL0, PSEL1, PSEL2, PSEL3
  );

  modport slave (
    output transfer, write, addr, wdata,
    output PRDATA0, PRDATA1, PRDATA2, PRDATA3,
    output PREADY0, PREADY1, PREADY2, PREADY3,
    input  ready, rdata, PADDR, PWRITE, PWDATA, PENABLE,
    input  PSEL0, PSEL1, PSEL2, PSEL3
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-master APB bridge: request pulse -> SETUP/ACCESS with 4-slot decode at 0x1000_0000.
// Optional APB_TIMEOUT_EN: force completion after 16 unanswered ACCESS cycles (rdata=DEADBEEF).
module apb_master_bridge (
  input  logic              PCLK,
  input  logic              PRESET,
  apb_master_bridge_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t      state;
  logic [3:0]  psel_q;
  logic [1:0]  slot_q;
  logic        mapped_q;
  logic [31:0] paddr_q, pwdata_q;
  logic        pwrite_q, penable_q;

  logic        req_mapped;
  logic [3:0]  req_psel;
  logic        sel_ready;
  logic [31:0] sel_rdata;
  logic        timeout;
  logic        done;

  // Decode the incoming request so PSEL can be registered alongside PADDR.
  always_comb begin
    req_mapped = (bus.addr[31:16] == 16'h1000) && (bus.addr[15:14] == 2'b00);
    req_psel   = 4'b0000;
    if (req_mapped) req_psel[bus.addr[13:12]] = 1'b1;
  end

  // Unmapped accesses behave as a zero-wait slave returning 0.
  always_comb begin
    sel_ready = 1'b1;
    sel_rdata = 32'h0;
    if (mapped_q) begin
      unique case (slot_q)
        2'd0: begin sel_ready = bus.PREADY0; sel_rdata = bus.PRDATA0; end
        2'd1: begin sel_ready = bus.PREADY1; sel_rdata = bus.PRDATA1; end
        2'd2: begin sel_ready = bus.PREADY2; sel_rdata = bus.PRDATA2; end
        2'd3: begin sel_ready = bus.PREADY3; sel_rdata = bus.PRDATA3; end
      endcase
    end
  end

`ifdef APB_TIMEOUT_EN
  logic [3:0] tmo_cnt;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET)                         tmo_cnt <= 4'h0;
    else if (state != ACCESS)            tmo_cnt <= 4'h0;
    else if (!sel_ready)                 tmo_cnt <= tmo_cnt + 4'h1;
  end

  assign timeout = (state == ACCESS) && !sel_ready && (tmo_cnt == 4'hF);
`else
  assign timeout = 1'b0;
`endif

  assign done      = (state == ACCESS) && (sel_ready || timeout);
  assign bus.ready = done;
  assign bus.rdata = (done && !pwrite_q) ? (timeout ? 32'hDEAD_BEEF : sel_rdata) : 32'h0;

  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state     <= IDLE;
      psel_q    <= 4'b0000;
      slot_q    <= 2'd0;
      mapped_q  <= 1'b0;
      paddr_q   <= 32'h0;
      pwdata_q  <= 32'h0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.transfer) begin
            state    <= SETUP;
            psel_q   <= req_psel;
            slot_q   <= bus.addr[13:12];
            mapped_q <= req_mapped;
            paddr_q  <= bus.addr;
            pwdata_q <= bus.wdata;
            pwrite_q <= bus.write;
          end
        end
        SETUP: begin
          state     <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (done) begin
            penable_q <= 1'b0;
            if (bus.transfer) begin
              state    <= SETUP;
              psel_q   <= req_psel;
              slot_q   <= bus.addr[13:12];
              mapped_q <= req_mapped;
              paddr_q  <= bus.addr;
              pwdata_q <= bus.wdata;
              pwrite_q <= bus.write;
            end else begin
              state  <= IDLE;
              psel_q <= 4'b0000;
            end
          end
        end
        default: begin
          state     <= IDLE;
          psel_q    <= 4'b0000;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.PADDR   = paddr_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PENABLE = penable_q;
  assign bus.PSEL0   = psel_q[0];
  assign bus.PSEL1   = psel_q[1];
  assign bus.PSEL2   = psel_q[2];
  assign bus.PSEL3   = psel_q[3];
endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge with four memory-backed APB slaves.
module tb_apb_master_bridge;
  logic PCLK = 1'b0;
  logic PRESET;
  apb_master_bridge_if bus();

  apb_master_bridge u_dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] addr, wdata, rdata;
    logic        write;
    logic [3:0]  psel;
    int          setup_cyc, rdy_cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, avail = 0, cur_wait = 0;
  logic [31:0] smem    [4][16];
  logic [31:0] ref_mem [4][16];
  logic [3:0]  prdy;
  logic [3:0]  pv;

  assign pv = {bus.PSEL3, bus.PSEL2, bus.PSEL1, bus.PSEL0};
  assign bus.PREADY0 = prdy[0];
  assign bus.PREADY1 = prdy[1];
  assign bus.PREADY2 = prdy[2];
  assign bus.PREADY3 = prdy[3];
  assign bus.PRDATA0 = smem[0][bus.PADDR[5:2]];
  assign bus.PRDATA1 = smem[1][bus.PADDR[5:2]];
  assign bus.PRDATA2 = smem[2][bus.PADDR[5:2]];
  assign bus.PRDATA3 = smem[3][bus.PADDR[5:2]];

  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave side: selected slave answers after cur_wait ACCESS cycles; unselected PREADYs toggle randomly.
  initial begin
    int wcnt;
    logic rdy;
    logic [3:0] junk;
    wcnt = 0;
    prdy = 4'h0;
    forever begin
      @(posedge PCLK);
      #1;
      if (pv != 4'h0 && bus.PENABLE) begin
        rdy = (wcnt == cur_wait);
        wcnt++;
      end else begin
        rdy  = 1'b0;
        wcnt = 0;
      end
      junk = 4'($urandom);
      for (int i = 0; i < 4; i++) prdy[i] = pv[i] ? rdy : junk[i];
    end
  end

  // Slave memories commit a write in the cycle the slave reports ready.
  initial begin
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) smem[i][j] = 32'hA000_0000 + 32'(i * 256 + j);
    forever begin
      @(negedge PCLK);
      if (PRESET && bus.PENABLE && bus.PWRITE)
        for (int i = 0; i < 4; i++)
          if (pv[i] && prdy[i]) smem[i][bus.PADDR[5:2]] = bus.PWDATA;
    end
  end

  // Monitor: phase checks against the in-flight expectation, pop on ready.
  always @(negedge PCLK) begin
    exp_t h;
    if (PRESET) begin
      chk("psel_at_most_one", 32'($countones(pv) <= 1), 32'd1);
      if (q.size() > 0) begin
        h = q[0];
        if (cyc == h.setup_cyc) begin
          chk("setup_penable", 32'(bus.PENABLE), 32'd0);
          chk("setup_psel", 32'(pv), 32'(h.psel));
          chk("setup_paddr", bus.PADDR, h.addr);
        end else if (cyc > h.setup_cyc && cyc < h.rdy_cyc) begin
          chk("wait_penable", 32'(bus.PENABLE), 32'd1);
          chk("wait_psel", 32'(pv), 32'(h.psel));
          chk("wait_paddr", bus.PADDR, h.addr);
          if (h.write) chk("wait_pwdata", bus.PWDATA, h.wdata);
        end
      end
      if (bus.ready) begin
        if (q.size() == 0) begin
          chk("spurious_ready", 32'd1, 32'd0);
        end else begin
          h = q.pop_front();
          chk("ready_cycle", 32'(cyc), 32'(h.rdy_cyc));
          chk("rdata", bus.rdata, h.rdata);
          chk("done_psel", 32'(pv), 32'(h.psel));
          chk("done_penable", 32'(bus.PENABLE), 32'd1);
          chk("done_pwrite", 32'(bus.PWRITE), 32'(h.write));
          chk("done_paddr", bus.PADDR, h.addr);
          if (h.write) chk("done_pwdata", bus.PWDATA, h.wdata);
        end
      end else begin
        chk("rdata_idle_zero", bus.rdata, 32'h0);
        if (q.size() > 0 && cyc > q[0].rdy_cyc) begin
          h = q.pop_front();
          chk("missing_ready", 32'd0, 32'd1);
        end
      end
    end
  end

  // Issue one request; called at a negedge. Expected response comes from the address map rules.
  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int wt_in, input bit b2b);
    exp_t e;
    int   slot, idx, v, wt;
    bit   mapped;
    mapped = (a >> 14) == 32'h4000;
    slot   = int'((a >> 12) & 32'h3);
    idx    = int'((a >> 2) & 32'hF);
    wt     = mapped ? wt_in : 0;
    // Requests during SETUP and ACCESS wait cycles must be ignored: drive noise there.
    while (cyc < avail) begin
      bus.transfer = 1'($urandom);
      bus.write    = 1'($urandom);
      bus.addr     = $urandom;
      bus.wdata    = $urandom;
      @(negedge PCLK);
    end
    if (!b2b) begin
      bus.transfer = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge PCLK);
    end
    v            = cyc;
    bus.transfer = 1'b1;
    bus.write    = w;
    bus.addr     = a;
    bus.wdata    = d;
    cur_wait     = wt;
    e.addr       = a;
    e.wdata      = d;
    e.write      = w;
    e.psel       = mapped ? 4'(1 << slot) : 4'h0;
    e.rdata      = (!w && mapped) ? ref_mem[slot][idx] : 32'h0;
    e.setup_cyc  = v + 1;
    e.rdy_cyc    = v + 2 + wt;
    if (w && mapped) ref_mem[slot][idx] = d;
    q.push_back(e);
    avail = v + 2 + wt;
    @(negedge PCLK);
    bus.transfer = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_paddr"},   bus.PADDR, 32'h0);
    chk({tag, "_pwrite"},  32'(bus.PWRITE), 32'd0);
    chk({tag, "_pwdata"},  bus.PWDATA, 32'h0);
    chk({tag, "_psel"},    32'(pv), 32'd0);
    chk({tag, "_penable"}, 32'(bus.PENABLE), 32'd0);
    chk({tag, "_ready"},   32'(bus.ready), 32'd0);
    chk({tag, "_rdata"},   bus.rdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 16; j++) ref_mem[i][j] = 32'hA000_0000 + 32'(i * 256 + j);
    PRESET       = 1'b0;
    bus.transfer = 1'b0;
    bus.write    = 1'b0;
    bus.addr     = 32'h0;
    bus.wdata    = 32'h0;
    #3;
    check_all_zero("reset");
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    avail  = cyc;

    // RAM write then read-back, zero wait.
    do_txn(1'b1, 32'h1000_0000, 32'd1, 0, 1'b0);
    do_txn(1'b1, 32'h1000_0004, 32'd2, 0, 1'b0);
    do_txn(1'b1, 32'h1000_0008, 32'd3, 0, 1'b0);
    do_txn(1'b0, 32'h1000_0000, 32'd0, 0, 1'b0);
    do_txn(1'b0, 32'h1000_0004, 32'd0, 0, 1'b0);
    do_txn(1'b0, 32'h1000_0008, 32'd0, 0, 1'b0);
    // Slot decode.
    do_txn(1'b1, 32'h1000_1000, 32'd11, 0, 1'b0);
    do_txn(1'b1, 32'h1000_2000, 32'd12, 0, 1'b0);
    do_txn(1'b0, 32'h1000_3000, 32'd0, 0, 1'b0);
    // Wait states on slot 1.
    do_txn(1'b1, 32'h1000_1004, 32'h5555_AAAA, 3, 1'b0);
    do_txn(1'b0, 32'h1000_1004, 32'd0, 3, 1'b0);
    // Unmapped addresses, including the edges of the mapped window.
    do_txn(1'b0, 32'h2000_0000, 32'd0, 0, 1'b0);
    do_txn(1'b1, 32'h1000_4000, 32'hDEAD_0001, 0, 1'b0);
    do_txn(1'b0, 32'h1001_0000, 32'd0, 0, 1'b0);
    do_txn(1'b0, 32'h1000_0000, 32'd0, 0, 1'b0);
    // Back-to-back with no idle bubble.
    do_txn(1'b1, 32'h1000_000C, 32'h0000_0077, 0, 1'b0);
    do_txn(1'b0, 32'h1000_000C, 32'd0, 0, 1'b1);
    do_txn(1'b1, 32'h1000_2010, 32'h1234_5678, 2, 1'b1);
    do_txn(1'b0, 32'h1000_2010, 32'd0, 1, 1'b1);

    // Reset during a stalled ACCESS aborts without a ready.
    while (cyc < avail) @(negedge PCLK);
    bus.transfer = 1'b0;
    @(negedge PCLK);
    bus.transfer = 1'b1;
    bus.write    = 1'b1;
    bus.addr     = 32'h1000_0000;
    bus.wdata    = 32'hFFFF_0000;
    cur_wait     = 10;
    @(negedge PCLK);
    bus.transfer = 1'b0;
    repeat (2) @(negedge PCLK);
    chk("pre_reset_penable", 32'(bus.PENABLE), 32'd1);
    #2 PRESET = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge PCLK);
    chk("held_reset_ready", 32'(bus.ready), 32'd0);
    PRESET = 1'b1;
    avail  = cyc;
    do_txn(1'b1, 32'h1000_0000, 32'h0000_0099, 0, 1'b0);
    do_txn(1'b0, 32'h1000_0000, 32'd0, 0, 1'b0);

    // Random mix of mapped/unmapped, reads/writes, wait states and back-to-back.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 8)
        a = 32'h1000_0000 | (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 15)) << 2);
      else
        case ($urandom_range(0, 3))
          0:       a = 32'h2000_0000 | ($urandom & 32'hFFC);
          1:       a = 32'h1000_4000 | ($urandom & 32'h3FFC);
          2:       a = 32'h1001_0000 | ($urandom & 32'hFFFC);
          default: a = 32'h0000_1000;
        endcase
      do_txn(1'($urandom), a, $urandom, $urandom_range(0, 4), 1'($urandom));
    end

    while (cyc < avail + 4) @(negedge PCLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
